// File: rtl/sbox_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sbox_pkg: shared types and defaults for the masked S-box issue path |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package sbox_pkg;

  localparam int SBOX_LAT = 4;

  // One in-flight slot: occupied flag plus which requester owns the result
  typedef struct packed {
    logic v;
    logic ks;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/sbox_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sbox_tag_pipe: LAT-deep tag shift register tracking in-flight ops   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sbox_tag_pipe
  import sbox_pkg::*;
#(
  parameter int LAT = SBOX_LAT
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [LAT-1:0] stage_q;
  tag_t [LAT-1:0] stage_d;

  // The S-box pipeline never stalls, so every stage advances each cycle
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/sbox_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sbox_issue_sched: round-robin issue scheduler for the masked S-box  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sbox_issue_sched
  import sbox_pkg::*;
#(
  parameter int LAT = SBOX_LAT,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic          ks_valid,
  output logic          ks_ready,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          sb_issue,
  output logic          sb_sel_ks,
  output logic          st_res_valid,
  output logic          ks_res_valid,
  output logic [CW-1:0] inflight,
  output logic          idle
);

  if ((LAT < 1) || (LAT > 15) || ((1 << CW) <= LAT)) begin : g_param_check
    $error("sbox_issue_sched: LAT must be 1..15 and 2**CW must exceed LAT");
  end

  logic          issue;
  logic          grant_ks;
  logic          last_ks_q, last_ks_d;
  logic [CW-1:0] inflight_q, inflight_d;
  tag_t          tag_in;
  tag_t          tag_out;

  // Key wins a contested cycle unless it took the previous grant
  always_comb begin
    issue      = rnd_valid & (st_valid | ks_valid);
    grant_ks   = issue & ks_valid & (~st_valid | ~last_ks_q);
    last_ks_d  = issue ? grant_ks : last_ks_q;
    tag_in.v   = issue;
    tag_in.ks  = grant_ks;
    inflight_d = inflight_q + CW'(issue) - CW'(tag_out.v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ks_q  <= 1'b0;
      inflight_q <= '0;
    end else begin
      last_ks_q  <= last_ks_d;
      inflight_q <= inflight_d;
    end
  end

  sbox_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign sb_issue     = issue;
  assign sb_sel_ks    = grant_ks;
  assign rnd_ready    = issue;
  assign st_ready     = issue & ~grant_ks;
  assign ks_ready     = grant_ks;
  assign st_res_valid = tag_out.v & ~tag_out.ks;
  assign ks_res_valid = tag_out.v & tag_out.ks;
  assign inflight     = inflight_q;
  assign idle         = (inflight_q == '0) & ~issue;

endmodule
`default_nettype wire

// File: tb/tb_sbox_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sbox_issue_sched: vector table, corner sequences, random vs model|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_sbox_issue_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st_valid = 1'b0;
  logic ks_valid = 1'b0;
  logic rnd_valid = 1'b0;

  always #5 clk = ~clk;

  logic       a_st_ready, a_ks_ready, a_rnd_ready, a_sb_issue, a_sb_sel_ks;
  logic       a_st_res_valid, a_ks_res_valid, a_idle;
  logic [3:0] a_inflight;
  logic       b_st_ready, b_ks_ready, b_rnd_ready, b_sb_issue, b_sb_sel_ks;
  logic       b_st_res_valid, b_ks_res_valid, b_idle;
  logic [1:0] b_inflight;

  sbox_issue_sched #(.LAT(4), .CW(4)) dut4 (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(a_st_ready),
    .ks_valid(ks_valid), .ks_ready(a_ks_ready),
    .rnd_valid(rnd_valid), .rnd_ready(a_rnd_ready),
    .sb_issue(a_sb_issue), .sb_sel_ks(a_sb_sel_ks),
    .st_res_valid(a_st_res_valid), .ks_res_valid(a_ks_res_valid),
    .inflight(a_inflight), .idle(a_idle)
  );

  sbox_issue_sched #(.LAT(1), .CW(2)) dut1 (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(b_st_ready),
    .ks_valid(ks_valid), .ks_ready(b_ks_ready),
    .rnd_valid(rnd_valid), .rnd_ready(b_rnd_ready),
    .sb_issue(b_sb_issue), .sb_sel_ks(b_sb_sel_ks),
    .st_res_valid(b_st_res_valid), .ks_res_valid(b_ks_res_valid),
    .inflight(b_inflight), .idle(b_idle)
  );

  wire [11:0] obs4 = {a_sb_issue, a_sb_sel_ks, a_st_ready, a_ks_ready, a_rnd_ready,
                      a_st_res_valid, a_ks_res_valid, a_idle, a_inflight};
  wire [11:0] obs1 = {b_sb_issue, b_sb_sel_ks, b_st_ready, b_ks_ready, b_rnd_ready,
                      b_st_res_valid, b_ks_res_valid, b_idle, 2'b00, b_inflight};

  int checks = 0;
  int errors = 0;

  // Reference model: per-cycle issue history; results/occupancy derived from it
  int cyc = 0;
  int epoch = 0;
  bit m_last_ks = 1'b0;
  bit hist_iss [2048];
  bit hist_ks  [2048];
  bit e_iss, e_sel;

  function automatic logic [11:0] pack_obs(bit iss, bit sel, bit sr, bit kr, int n);
    return {iss, sel, iss & ~sel, iss & sel, iss, sr, kr, (n == 0) && !iss, 4'(n)};
  endfunction

  function automatic logic [11:0] model_obs(int lat, bit iss, bit sel, bit in_rst);
    int n = 0;
    bit sr = 1'b0;
    bit kr = 1'b0;
    if (!in_rst) begin
      for (int j = cyc - lat; j < cyc; j++)
        if (j >= epoch && hist_iss[j]) n++;
      if ((cyc - lat) >= epoch && hist_iss[cyc-lat]) begin
        sr = !hist_ks[cyc-lat];
        kr = hist_ks[cyc-lat];
      end
    end
    return pack_obs(iss, sel, sr, kr, n);
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h (iss,sel,st_rdy,ks_rdy,rnd_rdy,st_res,ks_res,idle,inflight[3:0])",
               name, cyc, got, want);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit k, input bit n);
    @(negedge clk);
    rst = r; st_valid = s; ks_valid = k; rnd_valid = n;
    #1;
    if (r) m_last_ks = 1'b0;
    e_iss = n && (s || k);
    e_sel = e_iss && k && (!s || !m_last_ks);
    check("model_lat4", obs4, model_obs(4, e_iss, e_sel, r));
    check("model_lat1", obs1, model_obs(1, e_iss, e_sel, r));
    if (r) begin
      epoch = cyc + 1;
    end else begin
      hist_iss[cyc] = e_iss;
      hist_ks[cyc]  = e_sel;
      if (e_iss) m_last_ks = e_sel;
    end
    cyc++;
  endtask

  typedef struct {
    bit r, s, k, n;
    bit iss, sel, sr, kr;
    int inf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit s, bit k, bit n, bit iss, bit sel, bit sr, bit kr, int inf);
    vec_t v;
    v.r = r; v.s = s; v.k = k; v.n = n;
    v.iss = iss; v.sel = sel; v.sr = sr; v.kr = kr; v.inf = inf;
    tbl.push_back(v);
  endfunction

  initial begin
    bit sp, kp, r, n;

    // reset
    add(1,0,0,0, 0,0,0,0, 0);
    // single state op, result 4 cycles later
    add(0,1,0,1, 1,0,0,0, 0);
    add(0,0,0,0, 0,0,0,0, 1);
    add(0,0,0,0, 0,0,0,0, 1);
    add(0,0,0,0, 0,0,0,0, 1);
    add(0,0,0,0, 0,0,1,0, 1);
    add(0,0,0,0, 0,0,0,0, 0);
    // both requesting, alternating K,S,K,S,K,S
    add(0,1,1,1, 1,1,0,0, 0);
    add(0,1,1,1, 1,0,0,0, 1);
    add(0,1,1,1, 1,1,0,0, 2);
    add(0,1,1,1, 1,0,0,0, 3);
    add(0,1,1,1, 1,1,0,1, 4);
    add(0,1,1,1, 1,0,1,0, 4);
    add(0,0,0,0, 0,0,0,1, 4);
    add(0,0,0,0, 0,0,1,0, 3);
    add(0,0,0,0, 0,0,0,1, 2);
    add(0,0,0,0, 0,0,1,0, 1);
    add(0,0,0,0, 0,0,0,0, 0);
    // randomness toggling with both requesting
    add(0,1,1,1, 1,1,0,0, 0);
    add(0,1,1,0, 0,0,0,0, 1);
    add(0,1,1,1, 1,0,0,0, 1);
    add(0,1,1,0, 0,0,0,0, 2);
    add(0,0,0,0, 0,0,0,1, 2);
    add(0,0,0,0, 0,0,0,0, 1);
    add(0,0,0,0, 0,0,1,0, 1);
    add(0,0,0,0, 0,0,0,0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].k, tbl[i].n);
      check("table_lat4", obs4,
            pack_obs(tbl[i].iss, tbl[i].sel, tbl[i].sr, tbl[i].kr, tbl[i].inf));
    end

    // continuous issue: occupancy saturates at LAT, then drains
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // reset mid-flight: K,S,K leaves last grant on key; reset must drop results
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_immediate", {a_st_res_valid, a_ks_res_valid, a_inflight}, 6'd0);
    step(0, 1, 1, 1);
    check("rst_clears_last_ks", {11'd0, a_sb_sel_ks}, 12'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // randomized traffic; requesters hold valid until accepted
    sp = 1'b0;
    kp = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!sp) sp = 1'($urandom_range(0, 1));
      if (!kp) kp = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 63) == 0);
      step(r, sp, kp, n);
      if (e_iss) begin
        if (e_sel) kp = 1'b0;
        else       sp = 1'b0;
      end
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
